// File: rtl/wb_select_pipe.sv
// Registered write-back source selector with valid/ready output stage, per-source
// ready gating, and sticky bad-selector / wait-timeout error flags.
module wb_select_pipe #(
    parameter int DATA_W    = 32,
    parameter int N_SRC     = 8,
    parameter int SEL_W     = 4,
    parameter int CONST_IDX = 1,
    parameter int CONST_VAL = 227,
    parameter int TIMEOUT   = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [N_SRC-1:0]        src_rdy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    sel_err,
    output logic                    timeout_err,
    input  logic                    err_clr
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_SRC);

    logic              sel_bad;
    logic [SEL_W-1:0]  idx;
    logic [DATA_W-1:0] sel_data;
    logic              eff_rdy;
    logic              accept;
    logic              stall;
    logic              timeout_hit;
    logic [CNT_W-1:0]  wait_cnt;

    // Out-of-range selectors fall back to the last channel and are flagged.
    always_comb begin
        sel_bad  = (in_sel == '0) || (in_sel > SEL_LAST);
        idx      = sel_bad ? SEL_W'(N_SRC - 1) : (in_sel - SEL_W'(1));
        sel_data = '0;
        eff_rdy  = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (idx == SEL_W'(k)) begin
                if (k == CONST_IDX) begin
                    // The constant channel ignores its own data and ready lanes.
                    sel_data = DATA_W'(CONST_VAL) | (src_data[k*DATA_W +: DATA_W] & '0);
                    eff_rdy  = 1'b1 | src_rdy[k];
                end else begin
                    sel_data = src_data[k*DATA_W +: DATA_W];
                    eff_rdy  = src_rdy[k];
                end
            end
        end
    end

    assign in_ready    = eff_rdy & (~out_valid | out_ready);
    assign accept      = in_valid & in_ready;
    assign stall       = in_valid & ~eff_rdy;
    assign timeout_hit = stall && (wait_cnt == (CNT_MAX - CNT_W'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sel     <= '0;
            sel_err     <= 1'b0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            if (accept) begin
                out_data  <= sel_data;
                out_sel   <= in_sel;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // Only source stalls count; output back-pressure leaves the counter alone.
            if (stall) begin
                if (wait_cnt != CNT_MAX) begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end else if (accept || !in_valid) begin
                wait_cnt <= '0;
            end

            sel_err     <= (accept & sel_bad) | (sel_err & ~err_clr);
            timeout_err <= timeout_hit | (timeout_err & ~err_clr);
        end
    end

endmodule
